// File: rtl/wb_regfile_sb.sv
// WB-side GPR file with write-through bypass to two ID read ports, a per-register
// pending-write scoreboard that drives stall_id, and a registered write-back trace.
module wb_regfile_sb #(
  parameter int NREG = 32,
  parameter int CW   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        RegWrite_wb,
  input  logic [4:0]  A3_wb,
  input  logic [31:0] wd_wb,
  input  logic [31:0] pc_wb,
  input  logic [4:0]  A1_id,
  input  logic [4:0]  A2_id,
  output logic [31:0] rd1_id,
  output logic [31:0] rd2_id,
  input  logic        issue_en_id,
  input  logic [4:0]  issue_dst_id,
  input  logic        squash_en,
  input  logic [4:0]  squash_dst,
  output logic        stall_id,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_reg,
  output logic [31:0] trace_data,
  output logic        err_ovf,
  output logic        err_udf
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW+1:0] ONE_W   = (CW+2)'(1);

  logic [31:0]   gpr_q [NREG];
  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];

  logic          trace_valid_q;
  logic [31:0]   trace_pc_q;
  logic [4:0]    trace_reg_q;
  logic [31:0]   trace_data_q;
  logic          err_ovf_q;
  logic          err_udf_q;

  logic          retire;
  logic          issue_ok;
  logic          squash_ok;
  logic          pend1;
  logic          pend2;
  logic          ovf_hit;
  logic          udf_hit;
  logic [CW+1:0] sum;

  assign retire    = RegWrite_wb && (A3_wb != 5'd0);
  assign squash_ok = squash_en && (squash_dst != 5'd0);

  // Read ports: $0 first, then same-cycle WB bypass, then the array.
  assign rd1_id = (A1_id == 5'd0) ? 32'd0 :
                  (RegWrite_wb && (A3_wb == A1_id)) ? wd_wb : gpr_q[A1_id];
  assign rd2_id = (A2_id == 5'd0) ? 32'd0 :
                  (RegWrite_wb && (A3_wb == A2_id)) ? wd_wb : gpr_q[A2_id];

  // A write-back landing this cycle already resolves one pending write.
  assign pend1 = (A1_id != 5'd0) &&
                 (({1'b0, cnt_q[A1_id]} - {{CW{1'b0}}, (retire && (A3_wb == A1_id))}) != '0);
  assign pend2 = (A2_id != 5'd0) &&
                 (({1'b0, cnt_q[A2_id]} - {{CW{1'b0}}, (retire && (A3_wb == A2_id))}) != '0);

  assign stall_id = pend1 || pend2;
  assign issue_ok = issue_en_id && !stall_id && (issue_dst_id != 5'd0);

  // Net counter update; two guard bits catch both overflow and wrap below zero.
  always_comb begin
    ovf_hit = 1'b0;
    udf_hit = 1'b0;
    sum     = '0;
    for (int r = 0; r < NREG; r++) begin
      sum = {2'b00, cnt_q[r]};
      if (r != 0) begin
        if (issue_ok  && (issue_dst_id == 5'(r))) sum = sum + ONE_W;
        if (retire    && (A3_wb        == 5'(r))) sum = sum - ONE_W;
        if (squash_ok && (squash_dst   == 5'(r))) sum = sum - ONE_W;
      end
      if (sum[CW+1]) begin
        cnt_d[r] = '0;
        udf_hit  = 1'b1;
      end else if (sum > {2'b00, CNT_MAX}) begin
        cnt_d[r] = CNT_MAX;
        ovf_hit  = 1'b1;
      end else begin
        cnt_d[r] = sum[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) begin
        gpr_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_reg_q   <= '0;
      trace_data_q  <= '0;
      err_ovf_q     <= 1'b0;
      err_udf_q     <= 1'b0;
    end else begin
      if (retire) gpr_q[A3_wb] <= wd_wb;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      trace_valid_q <= retire;
      if (retire) begin
        trace_pc_q   <= pc_wb;
        trace_reg_q  <= A3_wb;
        trace_data_q <= wd_wb;
      end
      err_ovf_q <= err_ovf_q | ovf_hit;
      err_udf_q <= err_udf_q | udf_hit;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_reg   = trace_reg_q;
  assign trace_data  = trace_data_q;
  assign err_ovf     = err_ovf_q;
  assign err_udf     = err_udf_q;

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Bench for wb_regfile_sb: directed scoreboard scenarios, a random write/bypass
// loop, and a trace scoreboard fed at write time and drained from the trace port.
module tb_wb_regfile_sb;

  localparam int W = 69;  // {pc, reg, data}

  logic        clk = 1'b0;
  logic        reset_n;
  logic        RegWrite_wb;
  logic [4:0]  A3_wb;
  logic [31:0] wd_wb;
  logic [31:0] pc_wb;
  logic [4:0]  A1_id;
  logic [4:0]  A2_id;
  logic [31:0] rd1_id;
  logic [31:0] rd2_id;
  logic        issue_en_id;
  logic [4:0]  issue_dst_id;
  logic        squash_en;
  logic [4:0]  squash_dst;
  logic        stall_id;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_reg;
  logic [31:0] trace_data;
  logic        err_ovf;
  logic        err_udf;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  wb_regfile_sb dut (
    .clk(clk), .reset_n(reset_n),
    .RegWrite_wb(RegWrite_wb), .A3_wb(A3_wb), .wd_wb(wd_wb), .pc_wb(pc_wb),
    .A1_id(A1_id), .A2_id(A2_id), .rd1_id(rd1_id), .rd2_id(rd2_id),
    .issue_en_id(issue_en_id), .issue_dst_id(issue_dst_id),
    .squash_en(squash_en), .squash_dst(squash_dst),
    .stall_id(stall_id),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_reg(trace_reg),
    .trace_data(trace_data),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    RegWrite_wb  = 1'b0;
    A3_wb        = '0;
    wd_wb        = '0;
    pc_wb        = '0;
    A1_id        = '0;
    A2_id        = '0;
    issue_en_id  = 1'b0;
    issue_dst_id = '0;
    squash_en    = 1'b0;
    squash_dst   = '0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
    RegWrite_wb = 1'b1;
    A3_wb       = r;
    wd_wb       = d;
    pc_wb       = pc;
    if (r != 5'd0) exp_q.push_back({pc, r, d});
  endtask

  task automatic issue(input logic [4:0] r);
    issue_en_id  = 1'b1;
    issue_dst_id = r;
  endtask

  // Trace scoreboard: every observed trace must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && trace_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("trace_unexpected", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("trace_pc",   trace_pc,           e[68:37]);
        check("trace_reg",  {27'd0, trace_reg}, {27'd0, e[36:32]});
        check("trace_data", trace_data,         e[31:0]);
      end
    end
  end

  initial begin
    logic [4:0]  r;
    logic [31:0] d;
    set_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    A1_id = 5'd5;
    #1;
    check("rst_rd1",   rd1_id, 32'd0);
    check("rst_stall", {31'd0, stall_id}, 32'd0);
    check("rst_tv",    {31'd0, trace_valid}, 32'd0);
    check("rst_ovf",   {31'd0, err_ovf}, 32'd0);
    check("rst_udf",   {31'd0, err_udf}, 32'd0);

    // Write R5 and read it back the next cycle with a trace.
    set_idle(); issue(5'd5); tick();
    set_idle(); wb_write(5'd5, 32'h1234_5678, 32'h0000_3000); tick();
    set_idle(); A1_id = 5'd5; #1;
    check("t1_rd1", rd1_id, 32'h1234_5678);
    check("t1_tv",  {31'd0, trace_valid}, 32'd1);
    check("t1_treg", {27'd0, trace_reg}, 32'd5);
    tick();
    check("t1_tv_drop", {31'd0, trace_valid}, 32'd0);

    // Same-cycle bypass on port 2.
    set_idle(); issue(5'd8); tick();
    set_idle(); wb_write(5'd8, 32'hDEAD_BEEF, 32'h0000_3004); A2_id = 5'd8; #1;
    check("t2_rd2",   rd2_id, 32'hDEAD_BEEF);
    check("t2_stall", {31'd0, stall_id}, 32'd0);
    tick();

    // Scoreboard stall on R9 until its write-back.
    set_idle(); issue(5'd9); tick();
    set_idle(); A1_id = 5'd9; #1;
    check("t3_stall_a", {31'd0, stall_id}, 32'd1);
    tick(); #1;
    check("t3_stall_b", {31'd0, stall_id}, 32'd1);
    wb_write(5'd9, 32'hCAFE_F00D, 32'h0000_3008); #1;
    check("t3_wb_stall", {31'd0, stall_id}, 32'd0);
    check("t3_wb_rd1",   rd1_id, 32'hCAFE_F00D);
    tick();
    set_idle(); A1_id = 5'd9; #1;
    check("t3_after_stall", {31'd0, stall_id}, 32'd0);
    check("t3_after_rd1",   rd1_id, 32'hCAFE_F00D);

    // Two writes to R10 in flight, then squash.
    set_idle(); issue(5'd10); tick();
    tick();
    set_idle(); A1_id = 5'd10; wb_write(5'd10, 32'h0000_0A01, 32'h0000_300C); #1;
    check("t4_ret1_stall", {31'd0, stall_id}, 32'd1);
    tick();
    set_idle(); A1_id = 5'd10; #1;
    check("t4_cnt1_stall", {31'd0, stall_id}, 32'd1);
    wb_write(5'd10, 32'h0000_0A02, 32'h0000_3010); #1;
    check("t4_ret2_stall", {31'd0, stall_id}, 32'd0);
    tick();
    set_idle(); A1_id = 5'd10; #1;
    check("t4_cnt0_stall", {31'd0, stall_id}, 32'd0);
    set_idle(); issue(5'd10); tick();
    set_idle(); A1_id = 5'd10; squash_en = 1'b1; squash_dst = 5'd10; #1;
    check("t4_sq_stall", {31'd0, stall_id}, 32'd1);
    tick();
    set_idle(); A1_id = 5'd10; #1;
    check("t4_post_sq_stall", {31'd0, stall_id}, 32'd0);
    check("t4_post_sq_rd1",   rd1_id, 32'h0000_0A02);
    check("t4_udf",           {31'd0, err_udf}, 32'd0);

    // $0 writes and issues are ignored.
    set_idle(); wb_write(5'd0, 32'hFFFF_FFFF, 32'h0000_3014); issue(5'd0); #1;
    check("t5_rd1_same", rd1_id, 32'd0);
    tick();
    set_idle(); #1;
    check("t5_rd1",   rd1_id, 32'd0);
    check("t5_stall", {31'd0, stall_id}, 32'd0);
    check("t5_tv",    {31'd0, trace_valid}, 32'd0);
    check("t5_udf",   {31'd0, err_udf}, 32'd0);

    // Overflow on R3, then three retires drain it.
    check("t6_ovf_pre", {31'd0, err_ovf}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      set_idle(); issue(5'd3); tick();
    end
    set_idle(); #1;
    check("t6_ovf", {31'd0, err_ovf}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      set_idle(); A1_id = 5'd3; wb_write(5'd3, 32'h300 + i, 32'h3100 + 4 * i); #1;
      check("t6_drain_stall", {31'd0, stall_id}, (i == 2) ? 32'd0 : 32'd1);
      tick();
    end
    set_idle(); A1_id = 5'd3; #1;
    check("t6_cnt0_stall", {31'd0, stall_id}, 32'd0);
    check("t6_udf_pre",    {31'd0, err_udf}, 32'd0);
    wb_write(5'd4, 32'h0000_0044, 32'h0000_3200); tick();
    set_idle(); #1;
    check("t6_udf", {31'd0, err_udf}, 32'd1);

    // Mid-stream reset with R3 pending.
    issue(5'd3); tick();
    set_idle(); reset_n = 1'b0; tick();
    reset_n = 1'b1; A1_id = 5'd3; A2_id = 5'd5; #1;
    check("rst2_rd1",   rd1_id, 32'd0);
    check("rst2_rd2",   rd2_id, 32'd0);
    check("rst2_stall", {31'd0, stall_id}, 32'd0);
    check("rst2_ovf",   {31'd0, err_ovf}, 32'd0);
    check("rst2_udf",   {31'd0, err_udf}, 32'd0);
    check("rst2_tv",    {31'd0, trace_valid}, 32'd0);
    check("rst2_q",     exp_q.size(), 32'd0);

    // Random issue/write-back pairs with bypass and readback.
    for (int i = 0; i < 16; i++) begin
      r = 5'($urandom_range(1, 31));
      d = $urandom;
      set_idle(); issue(r); tick();
      set_idle(); A1_id = r; #1;
      check("rnd_stall", {31'd0, stall_id}, 32'd1);
      wb_write(r, d, 32'h4000 + 4 * i); A2_id = r; #1;
      check("rnd_byp_stall", {31'd0, stall_id}, 32'd0);
      check("rnd_byp_rd2",   rd2_id, d);
      tick();
      set_idle(); A1_id = r; #1;
      check("rnd_rd1", rd1_id, d);
    end
    check("rnd_udf", {31'd0, err_udf}, 32'd0);

    set_idle();
    repeat (2) tick();
    check("trace_q_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
